tile_dispatcher: RTL and testbench
==================================

TILE_DISPATCHER -- requirements
Module: tile_dispatcher

Interface
REQ-001 SHALL have parameter NUM_SOLVERS, default 4; number of attached tile solvers, 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 32; job word width, type field in bits [DATA_WIDTH-1:DATA_WIDTH-3].
REQ-003 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  job word available from host FIFO.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  job word (type field + payload).
REQ-007 SHALL have port in_end_of_stream  input  1  marks last word of a job.
REQ-008 SHALL have port in_ready  output  1  dispatcher accepts in_data this cycle.
REQ-009 SHALL have port sol_valid  output  NUM_SOLVERS  per-solver word valid.
REQ-010 SHALL have port sol_data  output  DATA_WIDTH  broadcast word, equal to in_data.
REQ-011 SHALL have port sol_end_of_stream  output  1  broadcast, equal to in_end_of_stream.
REQ-012 SHALL have port sol_ready  input  NUM_SOLVERS  per-solver in_ready.
REQ-013 SHALL have port sol_done  input  NUM_SOLVERS  per-solver out_valid; result available, solver free.
REQ-014 SHALL have port busy  output  NUM_SOLVERS  solver holds an unfinished job.
REQ-015 SHALL have port drop_error  output  1  one-cycle pulse: malformed job discarded.
REQ-016 SHALL have port jobs_dispatched  output  16  count of fully forwarded jobs, wraps at 65535->0.

Function
REQ-017 SHALL implement states IDLE, STREAM, DROP.
REQ-018 IDLE: in_ready=0, sol_valid=0; first word is inspected without being consumed.
REQ-019 IDLE with in_valid and type field != 0 SHALL go to DROP next cycle and pulse drop_error for that one cycle.
REQ-020 IDLE with in_valid, type field = 0 and some busy bit clear SHALL latch sel = first free index scanning upward from rr_ptr (wrapping), then go to STREAM next cycle.
REQ-021 IDLE with all solvers busy SHALL hold IDLE, consuming nothing.
REQ-022 STREAM: in_ready = sol_ready[sel]; sol_valid[sel] = in_valid; all other sol_valid bits 0; zero-cycle combinational pass-through.
REQ-023 STREAM: beat = in_valid & in_ready; beat with in_end_of_stream SHALL set busy[sel], set rr_ptr = (sel+1) mod NUM_SOLVERS, increment jobs_dispatched, return to IDLE.
REQ-024 DROP: in_ready=1, sol_valid=0; beat with in_end_of_stream SHALL return to IDLE; no counter change.
REQ-025 sol_done[i] while busy[i] SHALL clear busy[i] next cycle; sol_done[i] while not busy[i] SHALL be ignored.
REQ-026 sol_done[sel] in the same cycle as the end_of_stream beat for sel SHALL leave busy[sel]=1 (set wins).
REQ-027 busy[sel] SHALL be 0 during STREAM; solver is marked busy only at job end.
REQ-028 Single-word job (first word carries in_end_of_stream) SHALL be dispatched normally: one beat in STREAM.
REQ-029 in_valid low mid-job in STREAM or DROP SHALL hold state with no beat.

Reset
REQ-030 On reset: state=IDLE, sel=0, rr_ptr=0, busy=0, jobs_dispatched=0, drop_error=0, in_ready=0, sol_valid=0.
REQ-031 Reset mid-job SHALL abandon the job; the partially sent solver is not marked busy.

Structure
REQ-032 State encoding and TYPE_OUTPUT_ADDR=3'd0 SHALL live in the shared fractal package alongside the job-word type codes.
REQ-033 The round-robin free-solver search SHALL be one sub-module, rr_free_select (inputs busy, rr_ptr; outputs found, index).

Verification
REQ-034 Reset, then job {type0 1, type1 2, type2 3, type3 8 with eos} -> sol_valid[0] for 4 beats, busy=4'b0001, jobs_dispatched=1.
REQ-035 Two back-to-back jobs, no done -> first to solver 0, second to solver 1, busy=4'b0011.
REQ-036 All four busy, fifth job pending -> in_ready=0 held; pulse sol_done[2] -> next job goes to solver 2 within 2 cycles.
REQ-037 Job whose first word has type 2 -> drop_error one cycle, all 3 words consumed, no sol_valid, jobs_dispatched unchanged.
REQ-038 sol_ready[sel]=0 for 3 cycles mid-job and in_valid gap -> no beats lost or duplicated; sol_done[sel] coincident with eos beat -> busy[sel] stays 1.
REQ-039 Reset asserted after 2 of 4 words -> busy=0, state IDLE, next job goes to solver 0.

Source files
------------

// File: rtl/tile_dispatcher_pkg.sv
// Shared definitions for the tile dispatcher: FSM encoding and job-word type codes.
package tile_dispatcher_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDrop   = 2'd2
  } state_e;

  // Only jobs led by an output-address word are dispatched; anything else is dropped.
  localparam logic [2:0] TYPE_OUTPUT_ADDR = 3'd0;

  typedef enum logic [2:0] {
    TypeOutputAddr = 3'd0,
    TypeTileCoord  = 3'd1,
    TypePalette    = 3'd2,
    TypeIterLimit  = 3'd3
  } job_type_e;

endpackage

// File: rtl/rr_free_select.sv
// Round-robin search for the first non-busy solver, scanning upward from rr_ptr with wrap.
module rr_free_select #(
  parameter int unsigned NumSolvers = 4,
  parameter int unsigned IdxW       = (NumSolvers > 1) ? $clog2(NumSolvers) : 1
) (
  input  logic [NumSolvers-1:0] busy,
  input  logic [IdxW-1:0]       rr_ptr,
  output logic                  found,
  output logic [IdxW-1:0]       index
);

  always_comb begin
    int cand;
    logic [IdxW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    found    = 1'b0;
    index    = '0;
    // Walk offsets from farthest to nearest so the nearest free solver wins.
    for (int off = int'(NumSolvers) - 1; off >= 0; off--) begin
      cand = int'(rr_ptr) + off;
      if (cand >= int'(NumSolvers)) begin
        cand = cand - int'(NumSolvers);
      end
      cand_idx = IdxW'(cand);
      if (!busy[cand_idx]) begin
        found = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/tile_dispatcher.sv
// Routes host job streams to free tile solvers round-robin; malformed jobs are drained and dropped.
module tile_dispatcher
  import tile_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_SOLVERS = 4,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_end_of_stream,
  output logic                   in_ready,
  output logic [NUM_SOLVERS-1:0] sol_valid,
  output logic [DATA_WIDTH-1:0]  sol_data,
  output logic                   sol_end_of_stream,
  input  logic [NUM_SOLVERS-1:0] sol_ready,
  input  logic [NUM_SOLVERS-1:0] sol_done,
  output logic [NUM_SOLVERS-1:0] busy,
  output logic                   drop_error,
  output logic [15:0]            jobs_dispatched
);

  localparam int unsigned IdxW = $clog2(NUM_SOLVERS);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        sel_q, sel_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_SOLVERS-1:0] busy_q, busy_d;
  logic [15:0]            jobs_q, jobs_d;
  logic                   drop_error_q, drop_error_d;

  logic                   found;
  logic [IdxW-1:0]        free_idx;
  logic [2:0]             in_type;
  logic                   beat;

  assign in_type = in_data[DATA_WIDTH-1 -: 3];

  rr_free_select #(
    .NumSolvers (NUM_SOLVERS),
    .IdxW       (IdxW)
  ) u_rr_free_select (
    .busy   (busy_q),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .index  (free_idx)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    // Done on an idle solver is a no-op by construction of the mask.
    busy_d       = busy_q & ~sol_done;
    jobs_d       = jobs_q;
    drop_error_d = 1'b0;
    in_ready     = 1'b0;
    sol_valid    = '0;
    beat         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_type != TYPE_OUTPUT_ADDR) begin
            state_d      = StDrop;
            drop_error_d = 1'b1;
          end else if (found) begin
            sel_d   = free_idx;
            state_d = StStream;
          end
        end
      end
      StStream: begin
        in_ready         = sol_ready[sel_q];
        sol_valid[sel_q] = in_valid;
        beat             = in_valid & in_ready;
        if (beat && in_end_of_stream) begin
          // Setting after the done-mask lets a coincident done lose to the job end.
          busy_d[sel_q] = 1'b1;
          rr_ptr_d      = (sel_q == IdxW'(NUM_SOLVERS - 1)) ? '0 : sel_q + IdxW'(1);
          jobs_d        = jobs_q + 16'd1;
          state_d       = StIdle;
        end
      end
      StDrop: begin
        in_ready = 1'b1;
        if (in_valid && in_end_of_stream) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      rr_ptr_q     <= '0;
      busy_q       <= '0;
      jobs_q       <= '0;
      drop_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
      jobs_q       <= jobs_d;
      drop_error_q <= drop_error_d;
    end
  end

  assign sol_data          = in_data;
  assign sol_end_of_stream = in_end_of_stream;
  assign busy              = busy_q;
  assign drop_error        = drop_error_q;
  assign jobs_dispatched   = jobs_q;

endmodule

// File: tb/tb_tile_dispatcher.sv
// Directed bench for tile_dispatcher with a beat scoreboard fed by the stimulus driver.
module tb_tile_dispatcher;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_end_of_stream;
  logic        in_ready;
  logic [3:0]  sol_valid;
  logic [31:0] sol_data;
  logic        sol_end_of_stream;
  logic [3:0]  sol_ready;
  logic [3:0]  sol_done;
  logic [3:0]  busy;
  logic        drop_error;
  logic [15:0] jobs_dispatched;

  typedef struct {
    int          solver;
    logic [31:0] data;
    logic        eos;
  } beat_t;

  beat_t sb[$];
  int    n_checks;
  int    n_fail;
  int    drop_pulses;
  int    valid_cycles;

  tile_dispatcher #(
    .NUM_SOLVERS (4),
    .DATA_WIDTH  (32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_end_of_stream  (in_end_of_stream),
    .in_ready          (in_ready),
    .sol_valid         (sol_valid),
    .sol_data          (sol_data),
    .sol_end_of_stream (sol_end_of_stream),
    .sol_ready         (sol_ready),
    .sol_done          (sol_done),
    .busy              (busy),
    .drop_error        (drop_error),
    .jobs_dispatched   (jobs_dispatched)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] w(input int t, input int p);
    logic [2:0] tt;
    tt = 3'(t);
    return {tt, 29'(p)};
  endfunction

  // Every solver-side beat must match the oldest outstanding expectation.
  always @(negedge clock) begin
    logic [3:0] beats;
    beat_t      e;
    #2;
    if (!reset) begin
      if (drop_error) drop_pulses++;
      if (sol_valid != 4'b0) valid_cycles++;
      beats = sol_valid & sol_ready;
      if (beats != 4'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(beats), 32'h0);
        end else begin
          e = sb.pop_front();
          check("beat_solver", 32'(beats), 32'(4'b0001 << e.solver));
          check("beat_data", sol_data, e.data);
          check("beat_eos", 32'(sol_end_of_stream), 32'(e.eos));
        end
      end
    end
  end

  // Drive one word and wait (bounded) for its handshake; solver < 0 means no beat expected.
  task automatic drive_word(input logic [31:0] d, input logic eos, input int solver);
    beat_t e;
    bit    got;
    got = 1'b0;
    if (solver >= 0) begin
      e.solver = solver;
      e.data   = d;
      e.eos    = eos;
      sb.push_back(e);
    end
    @(negedge clock);
    in_valid         = 1'b1;
    in_data          = d;
    in_end_of_stream = eos;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("handshake", 32'(got), 32'h1);
    @(posedge clock);
    #1;
    in_valid         = 1'b0;
    in_end_of_stream = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = 1'b0;
    sol_done  = 4'b0;
    sol_ready = 4'hF;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    static int vc0 = 0;
    static bit hit = 1'b0;
    beat_t     e;
    n_checks         = 0;
    n_fail           = 0;
    drop_pulses      = 0;
    valid_cycles     = 0;
    reset            = 1'b1;
    in_valid         = 1'b0;
    in_data          = '0;
    in_end_of_stream = 1'b0;
    sol_ready        = 4'hF;
    sol_done         = 4'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_sol_valid", 32'(sol_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_jobs", 32'(jobs_dispatched), 32'h0);
    check("rst_drop_error", 32'(drop_error), 32'h0);

    // Four-word job lands on solver 0.
    drive_word(w(0, 1), 1'b0, 0);
    drive_word(w(1, 2), 1'b0, 0);
    drive_word(w(2, 3), 1'b0, 0);
    drive_word(w(3, 8), 1'b1, 0);
    @(negedge clock); #1;
    check("job1_busy", 32'(busy), 32'h1);
    check("job1_jobs", 32'(jobs_dispatched), 32'h1);

    // Back-to-back jobs after reset go to solvers 0 then 1, then fill 2 and 3.
    do_reset();
    drive_word(w(0, 16'h100), 1'b0, 0);
    drive_word(w(1, 16'h101), 1'b1, 0);
    drive_word(w(0, 16'h200), 1'b0, 1);
    drive_word(w(2, 16'h201), 1'b1, 1);
    @(negedge clock); #1;
    check("b2b_busy", 32'(busy), 32'h3);
    check("b2b_jobs", 32'(jobs_dispatched), 32'h2);
    drive_word(w(0, 16'h300), 1'b1, 2);
    drive_word(w(0, 16'h400), 1'b1, 3);
    @(negedge clock); #1;
    check("full_busy", 32'(busy), 32'hF);

    // Fifth single-word job waits until solver 2 reports done.
    e.solver = 2;
    e.data   = w(0, 16'h500);
    e.eos    = 1'b1;
    sb.push_back(e);
    @(negedge clock);
    in_valid         = 1'b1;
    in_data          = w(0, 16'h500);
    in_end_of_stream = 1'b1;
    repeat (3) begin
      #1;
      check("full_hold_ready", 32'(in_ready), 32'h0);
      check("full_hold_valid", 32'(sol_valid), 32'h0);
      @(negedge clock);
    end
    sol_done = 4'b0100;
    @(negedge clock);
    sol_done = 4'b0;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      if (in_ready && sol_valid == 4'b0100) begin
        hit = 1'b1;
        break;
      end
    end
    check("freed_solver2", 32'(hit), 32'h1);
    @(posedge clock); #1;
    in_valid         = 1'b0;
    in_end_of_stream = 1'b0;
    @(negedge clock); #1;
    check("refill_busy", 32'(busy), 32'hF);
    check("refill_jobs", 32'(jobs_dispatched), 32'h5);

    // Malformed job: drained, flagged once, never forwarded.
    drop_pulses = 0;
    vc0         = valid_cycles;
    drive_word(w(2, 16'h600), 1'b0, -1);
    drive_word(w(0, 16'h601), 1'b0, -1);
    drive_word(w(1, 16'h602), 1'b1, -1);
    @(negedge clock); @(negedge clock); #3;
    check("drop_pulses", 32'(drop_pulses), 32'h1);
    check("drop_no_valid", 32'(valid_cycles - vc0), 32'h0);
    check("drop_jobs", 32'(jobs_dispatched), 32'h5);

    // Backpressure stall and input gap, then done coincident with the final beat.
    do_reset();
    drive_word(w(0, 16'h700), 1'b0, 0);
    sol_ready = 4'b1110;
    fork
      drive_word(w(1, 16'h701), 1'b0, 0);
      begin
        repeat (3) begin
          @(negedge clock);
          #1;
          check("stall_in_ready", 32'(in_ready), 32'h0);
        end
        @(negedge clock);
        sol_ready = 4'hF;
      end
    join
    repeat (2) @(negedge clock);
    drive_word(w(2, 16'h702), 1'b0, 0);
    sol_done = 4'b0001;
    drive_word(w(3, 16'h703), 1'b1, 0);
    sol_done = 4'b0;
    @(negedge clock); #3;
    check("set_wins_busy", 32'(busy), 32'h1);
    check("stall_jobs", 32'(jobs_dispatched), 32'h1);
    check("stall_sb_empty", 32'(sb.size()), 32'h0);

    // Reset mid-job abandons it; the next job starts over at solver 0.
    drive_word(w(0, 16'h800), 1'b0, 1);
    drive_word(w(1, 16'h801), 1'b0, 1);
    do_reset();
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_jobs", 32'(jobs_dispatched), 32'h0);
    check("midrst_sol_valid", 32'(sol_valid), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    drive_word(w(0, 16'h900), 1'b0, 0);
    drive_word(w(3, 16'h901), 1'b1, 0);
    @(negedge clock); #3;
    check("post_rst_busy", 32'(busy), 32'h1);
    check("post_rst_jobs", 32'(jobs_dispatched), 32'h1);
    check("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
